// File: rtl/acc_prd_arbiter.sv
// Round-robin arbiter sharing one combinational acc_predecoder among NumReq requesters.
// One transaction in flight: grant, predecoder lookup, registered response handshake.
module acc_prd_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned InstrW = 32,
  parameter int unsigned WbW    = 1,
  parameter int unsigned NumRs  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  input  logic [NumReq*InstrW-1:0] req_instr_i,
  output logic [NumReq-1:0]        req_ready_o,
  output logic [NumReq-1:0]        rsp_valid_o,
  input  logic [NumReq-1:0]        rsp_ready_i,
  output logic                     rsp_accept_o,
  output logic [WbW-1:0]           rsp_writeback_o,
  output logic [NumRs-1:0]         rsp_use_rs_o,
  output logic [InstrW-1:0]        prd_instr_o,
  input  logic                     prd_accept_i,
  input  logic [WbW-1:0]           prd_writeback_i,
  input  logic [NumRs-1:0]         prd_use_rs_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_ptr;
  logic [IdxW-1:0]     r_idx;
  logic [InstrW-1:0]   r_instr;
  logic [NumReq-1:0]   r_rsp_valid;
  logic                r_accept;
  logic [WbW-1:0]      r_wb;
  logic [NumRs-1:0]    r_use_rs;

  logic                w_hs;
  logic                w_grant;
  logic [IdxW-1:0]     w_idx_inc;
  logic [IdxW-1:0]     w_base;
  logic [IdxW-1:0]     w_gnt;
  logic [InstrW-1:0]   w_gnt_instr;

  // First valid index at or above base, wrapping explicitly for non-power-of-2 NumReq.
  function automatic logic [IdxW-1:0] f_pick(input logic [NumReq-1:0] v,
                                             input logic [IdxW-1:0]   base);
    logic [2*NumReq-1:0] dbl;
    logic [NumReq-1:0]   rot;
    logic [IdxW:0]       sum;
    logic [IdxW-1:0]     pick;
    dbl  = {v, v};
    rot  = NumReq'(dbl >> base);
    sum  = '0;
    pick = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, base} + (IdxW + 1)'(k);
        if (sum >= (IdxW + 1)'(NumReq)) sum = sum - (IdxW + 1)'(NumReq);
        pick = sum[IdxW-1:0];
      end
    end
    return pick;
  endfunction

  // r_rsp_valid is one-hot on r_idx, so this ignores other requesters' ready.
  assign w_hs      = (r_state == StResp) && (|(rsp_ready_i & r_rsp_valid));
  assign w_idx_inc = (r_idx == IdxW'(NumReq - 1)) ? '0 : r_idx + IdxW'(1);
  assign w_base    = (r_state == StResp) ? w_idx_inc : r_ptr;
  assign w_gnt     = f_pick(req_valid_i, w_base);
  assign w_grant   = !rst_i && (|req_valid_i) && ((r_state == StIdle) || w_hs);

  always_comb begin
    w_gnt_instr = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_gnt == IdxW'(i)) w_gnt_instr = req_instr_i[i*InstrW +: InstrW];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_instr     <= '0;
      r_rsp_valid <= '0;
      r_accept    <= 1'b0;
      r_wb        <= '0;
      r_use_rs    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_idx   <= w_gnt;
            r_instr <= w_gnt_instr;
            r_state <= StLookup;
          end
        end
        StLookup: begin
          r_accept    <= prd_accept_i;
          r_wb        <= prd_writeback_i;
          r_use_rs    <= prd_use_rs_i;
          r_rsp_valid <= NumReq'(1) << r_idx;
          r_instr     <= '0;
          r_state     <= StResp;
        end
        StResp: begin
          if (w_hs) begin
            r_ptr       <= w_idx_inc;
            r_rsp_valid <= '0;
            r_accept    <= 1'b0;
            r_wb        <= '0;
            r_use_rs    <= '0;
            if (w_grant) begin
              r_idx   <= w_gnt;
              r_instr <= w_gnt_instr;
              r_state <= StLookup;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready_o     = w_grant ? (NumReq'(1) << w_gnt) : '0;
  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_accept_o    = r_accept;
  assign rsp_writeback_o = r_wb;
  assign rsp_use_rs_o    = r_use_rs;
  assign prd_instr_o     = r_instr;

endmodule

// File: tb/tb_acc_prd_arbiter.sv
// Directed bench for acc_prd_arbiter: a 2-requester instance and a 3-requester wrap instance.
module tb_acc_prd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  rv = '0;
  logic [63:0] ri = '0;
  logic [1:0]  rr = '0;
  logic [1:0]  rdy, rspv;
  logic        acc;
  logic [0:0]  wb;
  logic [2:0]  urs;
  logic [31:0] pinstr;
  logic        pa = 1'b0;
  logic [0:0]  pw = '0;
  logic [2:0]  pu = '0;

  logic [2:0]  rv3 = '0;
  logic [95:0] ri3 = '0;
  logic [2:0]  rr3 = '0;
  logic [2:0]  rdy3, rspv3;
  logic        acc3;
  logic [0:0]  wb3;
  logic [2:0]  urs3;
  logic [31:0] pinstr3;
  logic        pa3 = 1'b1;
  logic [0:0]  pw3 = 1'b0;
  logic [2:0]  pu3 = 3'b001;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acc_prd_arbiter #(.NumReq(2), .InstrW(32), .WbW(1), .NumRs(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(rv), .req_instr_i(ri), .req_ready_o(rdy),
    .rsp_valid_o(rspv), .rsp_ready_i(rr),
    .rsp_accept_o(acc), .rsp_writeback_o(wb), .rsp_use_rs_o(urs),
    .prd_instr_o(pinstr), .prd_accept_i(pa), .prd_writeback_i(pw), .prd_use_rs_i(pu)
  );

  acc_prd_arbiter #(.NumReq(3), .InstrW(32), .WbW(1), .NumRs(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(rv3), .req_instr_i(ri3), .req_ready_o(rdy3),
    .rsp_valid_o(rspv3), .rsp_ready_i(rr3),
    .rsp_accept_o(acc3), .rsp_writeback_o(wb3), .rsp_use_rs_o(urs3),
    .prd_instr_o(pinstr3), .prd_accept_i(pa3), .prd_writeback_i(pw3), .prd_use_rs_i(pu3)
  );

  // Contention schedule with rsp_ready tied high: one grant every 2 cycles, 0,1,0,1.
  logic [1:0]  exp_rdy  [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  logic [1:0]  exp_rspv [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rv = '0; rr = '0; rv3 = '0; rr3 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = 2'b11; rv3 = 3'b111; ri = {32'hAAAA_0001, 32'hAAAA_0000};
    repeat (2) cyc();
    #1;
    n_cmp++; if (rdy !== 2'b00) begin n_err++; $display("FAIL rst_ready got %b want 00", rdy); end
    n_cmp++; if (rspv !== 2'b00) begin n_err++; $display("FAIL rst_rspv got %b want 00", rspv); end
    n_cmp++; if ({acc, wb, urs} !== 5'b0) begin
      n_err++; $display("FAIL rst_rsp got %b want 00000", {acc, wb, urs});
    end
    n_cmp++; if (pinstr !== 32'h0) begin n_err++; $display("FAIL rst_prd got %h want 0", pinstr); end
    n_cmp++; if (rdy3 !== 3'b000) begin n_err++; $display("FAIL rst_ready3 got %b want 000", rdy3); end
    rv = '0; rv3 = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    rv = 2'b01; ri = {32'h0, 32'h0000_000B}; rr = 2'b00; #1;
    n_cmp++; if (rdy !== 2'b01) begin n_err++; $display("FAIL single_grant got %b want 01", rdy); end
    cyc(); rv = 2'b00; pa = 1'b1; pw = 1'b1; pu = 3'b011; #1;
    n_cmp++; if (pinstr !== 32'h0000_000B) begin
      n_err++; $display("FAIL single_prd got %h want 0000000b", pinstr);
    end
    n_cmp++; if (rspv !== 2'b00) begin n_err++; $display("FAIL single_t1 got %b want 00", rspv); end
    cyc(); rr = 2'b01; #1;
    n_cmp++; if (rspv !== 2'b01) begin n_err++; $display("FAIL single_rspv got %b want 01", rspv); end
    n_cmp++; if ({acc, wb, urs} !== 5'b11011) begin
      n_err++; $display("FAIL single_rsp got %b want 11011", {acc, wb, urs});
    end
    n_cmp++; if (pinstr !== 32'h0) begin n_err++; $display("FAIL single_prd0 got %h want 0", pinstr); end
    cyc(); #1;
    n_cmp++; if ({rspv, acc, wb, urs} !== 7'b0) begin
      n_err++; $display("FAIL single_idle got %b want 0000000", {rspv, acc, wb, urs});
    end
    rr = 2'b00;
  endtask

  task automatic test_contention();
    do_reset();
    rv = 2'b11; rr = 2'b11; ri = {32'h0000_0022, 32'h0000_0011};
    pa = 1'b1; pw = 1'b0; pu = 3'b101;
    for (int c = 0; c < 7; c++) begin
      #1;
      n_cmp++; if (rdy !== exp_rdy[c]) begin
        n_err++; $display("FAIL cont_ready[%0d] got %b want %b", c, rdy, exp_rdy[c]);
      end
      n_cmp++; if (rspv !== exp_rspv[c]) begin
        n_err++; $display("FAIL cont_rspv[%0d] got %b want %b", c, rspv, exp_rspv[c]);
      end
      if (c == 3) begin
        n_cmp++; if (pinstr !== 32'h0000_0022) begin
          n_err++; $display("FAIL cont_prd got %h want 00000022", pinstr);
        end
      end
      if (c == 4) begin
        n_cmp++; if (urs !== 3'b101) begin
          n_err++; $display("FAIL cont_urs got %b want 101", urs);
        end
      end
      cyc();
    end
    rv = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    rv = 2'b01; ri = {32'h0000_00B1, 32'h0000_00B0}; rr = 2'b00; #1;
    n_cmp++; if (rdy !== 2'b01) begin n_err++; $display("FAIL bp_grant got %b want 01", rdy); end
    cyc(); rv = 2'b10; pa = 1'b1; pw = 1'b1; pu = 3'b110; #1;
    n_cmp++; if (rdy !== 2'b00) begin n_err++; $display("FAIL bp_lookup_rdy got %b want 00", rdy); end
    for (int c = 0; c < 5; c++) begin
      cyc(); rr = (c % 2 == 1) ? 2'b10 : 2'b00; pa = 1'b0; pw = 1'b0; pu = 3'b001; #1;
      n_cmp++; if ({rspv, acc, wb, urs} !== 7'b01_1_1_110) begin
        n_err++; $display("FAIL bp_hold[%0d] got %b want 0111110", c, {rspv, acc, wb, urs});
      end
      n_cmp++; if (rdy !== 2'b00) begin
        n_err++; $display("FAIL bp_rdy[%0d] got %b want 00", c, rdy);
      end
    end
    cyc(); rr = 2'b01; #1;
    n_cmp++; if (rdy !== 2'b10) begin n_err++; $display("FAIL bp_regrant got %b want 10", rdy); end
    cyc(); rv = 2'b00; rr = 2'b00; #1;
    n_cmp++; if (pinstr !== 32'h0000_00B1) begin
      n_err++; $display("FAIL bp_prd got %h want 000000b1", pinstr);
    end
    n_cmp++; if (rspv !== 2'b00) begin n_err++; $display("FAIL bp_rspv0 got %b want 00", rspv); end
  endtask

  task automatic test_reject();
    do_reset();
    rv = 2'b01; ri = {32'h0000_00C1, 32'h0000_00C0}; #1;
    n_cmp++; if (rdy !== 2'b01) begin n_err++; $display("FAIL rej_grant got %b want 01", rdy); end
    cyc(); rv = 2'b00; pa = 1'b0; pw = 1'b0; pu = 3'b000;
    cyc(); rr = 2'b01; #1;
    n_cmp++; if ({rspv, acc, wb, urs} !== 7'b01_0_0_000) begin
      n_err++; $display("FAIL rej_rsp got %b want 0100000", {rspv, acc, wb, urs});
    end
    cyc(); rr = 2'b00; rv = 2'b11; #1;
    n_cmp++; if (rdy !== 2'b10) begin n_err++; $display("FAIL rej_ptr got %b want 10", rdy); end
    cyc(); rv = 2'b00;
  endtask

  task automatic test_async_reset();
    do_reset();
    rv = 2'b10; ri = {32'h0000_00D1, 32'h0000_00D0}; rr = 2'b00; #1;
    n_cmp++; if (rdy !== 2'b10) begin n_err++; $display("FAIL ar_grant got %b want 10", rdy); end
    cyc(); rv = 2'b00; pa = 1'b1; pw = 1'b1; pu = 3'b111;
    cyc(); #1;
    n_cmp++; if ({rspv, urs} !== 5'b10_111) begin
      n_err++; $display("FAIL ar_resp got %b want 10111", {rspv, urs});
    end
    rv = 2'b11; #2; rst = 1'b1; #1;
    n_cmp++; if ({rdy, rspv, acc, wb, urs} !== 9'b0) begin
      n_err++; $display("FAIL ar_outs got %b want 000000000", {rdy, rspv, acc, wb, urs});
    end
    n_cmp++; if (pinstr !== 32'h0) begin n_err++; $display("FAIL ar_prd got %h want 0", pinstr); end
    cyc(); rst = 1'b0; #1;
    n_cmp++; if (rdy !== 2'b01) begin n_err++; $display("FAIL ar_first got %b want 01", rdy); end
    cyc(); rv = 2'b00;
  endtask

  task automatic test_wrap3();
    do_reset();
    rv3 = 3'b010; ri3 = {32'h0000_0E02, 32'h0000_0E01, 32'h0000_0E00}; rr3 = 3'b111; #1;
    n_cmp++; if (rdy3 !== 3'b010) begin n_err++; $display("FAIL w3_g1 got %b want 010", rdy3); end
    cyc(); rv3 = 3'b000;
    cyc(); #1;
    n_cmp++; if (rspv3 !== 3'b010) begin n_err++; $display("FAIL w3_rsp1 got %b want 010", rspv3); end
    cyc(); rv3 = 3'b011; #1;
    n_cmp++; if (rdy3 !== 3'b001) begin n_err++; $display("FAIL w3_wrap got %b want 001", rdy3); end
    cyc(); rv3 = 3'b010; #1;
    n_cmp++; if (pinstr3 !== 32'h0000_0E00) begin
      n_err++; $display("FAIL w3_prd got %h want 00000e00", pinstr3);
    end
    cyc(); #1;
    n_cmp++; if (rspv3 !== 3'b001) begin n_err++; $display("FAIL w3_rsp0 got %b want 001", rspv3); end
    n_cmp++; if (rdy3 !== 3'b010) begin n_err++; $display("FAIL w3_g2 got %b want 010", rdy3); end
    cyc(); rv3 = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reject();
    test_async_reset();
    test_wrap3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
